// File: rtl/chacha_state_feeder.sv
// ChaCha input-state feeder: holds host-loaded key/counter/nonce and streams the
// 64-byte initial state (constants, key, counter, nonce) as handshaked byte writes.
module chacha_state_feeder #(
  parameter bit          AUTO_INC   = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic       cfg_err,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ctr_wrap,
  input  logic       blk_ready,
  output logic       out_write,
  output logic [7:0] out_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [127:0] SIGMA    = "expand 32-byte k";
  localparam logic [3:0]   GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [1:0]  state;
  logic [5:0]  idx;
  logic [3:0]  gap_cnt;
  logic [7:0]  key   [32];
  logic [7:0]  nonce [12];
  logic [31:0] ctr;
  logic [7:0]  cur_byte;
  logic [3:0]  sigma_sel;
  logic        cfg_wr;
  logic        transfer;

  assign cfg_wr    = cfg_valid && (state == S_IDLE);
  assign transfer  = (state == S_STREAM) && blk_ready;
  assign sigma_sel = 4'd15 - idx[3:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cur_byte = 8'h00;
    if (idx < 6'd16)      cur_byte = SIGMA[{sigma_sel, 3'b000} +: 8];
    else if (idx < 6'd48) cur_byte = key[5'(idx - 6'd16)];
    else if (idx < 6'd52) cur_byte = ctr[{idx[1:0], 3'b000} +: 8];
    else                  cur_byte = nonce[4'(idx - 6'd52)];
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_write = transfer;
  assign out_data  = (state == S_STREAM) ? cur_byte : 8'h00;

  // NOTE: sequential state is assigned with non-blocking <= so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 6'd0;
      gap_cnt <= 4'd0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_valid && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_STREAM;
            idx   <= 6'd0;
          end
        end
        S_STREAM: begin
          if (blk_ready) begin
            idx <= idx + 6'd1;
            if (idx == 6'd63) begin
              state <= S_DONE;
            end else if (GAP_CYCLES != 0) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_STREAM;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: key and nonce are small flop arrays, not RAM, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) key[i] <= 8'h00;
      for (int i = 0; i < 12; i++) nonce[i] <= 8'h00;
      ctr      <= 32'h0;
      ctr_wrap <= 1'b0;
    end else if (cfg_wr) begin
      if (cfg_addr < 6'd32) begin
        key[cfg_addr[4:0]] <= cfg_data;
      end else if (cfg_addr < 6'd36) begin
        ctr[{cfg_addr[1:0], 3'b000} +: 8] <= cfg_data;
        ctr_wrap <= 1'b0;
      end else if (cfg_addr < 6'd48) begin
        nonce[4'(cfg_addr - 6'd36)] <= cfg_data;
      end
    end else if ((state == S_DONE) && AUTO_INC) begin
      // Streamed counter bytes were the pre-increment value; advance for the next block.
      ctr <= ctr + 32'd1;
      if (ctr == 32'hFFFF_FFFF) ctr_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chacha_state_feeder.sv
// Directed bench: RFC 8439 state layout, stall, counter wrap, busy config, reset
// mid-stream, and a GAP_CYCLES=2 / AUTO_INC=0 build.
module tb_chacha_state_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       start, cfg_valid, blk_ready;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;

  logic       start_a, start_b, cfg_valid_a, cfg_valid_b;
  logic       cfg_err_a, busy_a, done_a, ctr_wrap_a, out_write_a;
  logic       cfg_err_b, busy_b, done_b, ctr_wrap_b, out_write_b;
  logic [7:0] out_data_a, out_data_b;

  assign start_a     = start && !sel;
  assign start_b     = start && sel;
  assign cfg_valid_a = cfg_valid && !sel;
  assign cfg_valid_b = cfg_valid && sel;

  chacha_state_feeder #(.AUTO_INC(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid_a), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err_a), .start(start_a), .busy(busy_a), .done(done_a), .ctr_wrap(ctr_wrap_a),
    .blk_ready(blk_ready), .out_write(out_write_a), .out_data(out_data_a)
  );

  chacha_state_feeder #(.AUTO_INC(1'b0), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid_b), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err_b), .start(start_b), .busy(busy_b), .done(done_b), .ctr_wrap(ctr_wrap_b),
    .blk_ready(blk_ready), .out_write(out_write_b), .out_data(out_data_b)
  );

  logic       ow, bz, dn, ce;
  logic [7:0] od;
  assign ow = sel ? out_write_b : out_write_a;
  assign bz = sel ? busy_b : busy_a;
  assign dn = sel ? done_b : done_a;
  assign ce = sel ? cfg_err_b : cfg_err_a;
  assign od = sel ? out_data_b : out_data_a;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model, one copy per DUT (0 = dut_a, 1 = dut_b).
  logic [7:0]  sigma_tb [16] = '{8'h65, 8'h78, 8'h70, 8'h61, 8'h6e, 8'h64, 8'h20, 8'h33,
                                 8'h32, 8'h2d, 8'h62, 8'h79, 8'h74, 8'h65, 8'h20, 8'h6b};
  logic [7:0]  m_key   [2][32];
  logic [7:0]  m_nonce [2][12];
  logic [31:0] m_ctr   [2];

  logic [7:0]  cap [64];
  int          wc  [64];
  int          nw;
  int          done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int s, input int i);
    if (i < 16)      return sigma_tb[i];
    else if (i < 48) return m_key[s][i-16];
    else if (i < 52) return m_ctr[s][8*(i-48) +: 8];
    else             return m_nonce[s][i-52];
  endfunction

  task automatic model_write(input int s, input int a, input logic [7:0] d);
    if (a < 32)      m_key[s][a] = d;
    else if (a < 36) m_ctr[s][8*(a-32) +: 8] = d;
    else if (a < 48) m_nonce[s][a-36] = d;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32; i++) m_key[s][i] = 8'h00;
      for (int i = 0; i < 12; i++) m_nonce[s][i] = 8'h00;
      m_ctr[s] = 32'h0;
    end
  endtask

  task automatic cfg_write(input int a, input logic [7:0] d);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = 6'(a); cfg_data = d;
    model_write(sel ? 1 : 0, a, d);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Streams one state; optional stall at byte stall_idx, busy config write at byte
  // cfg_idx, and a config write issued together with start (sim_addr >= 0).
  task automatic run_stream(input int stall_idx, input int stall_len, input int cfg_idx,
                            input int sim_addr, input logic [7:0] sim_data);
    int s, gap, stalled, cfg_cyc, bad, exp_wc;
    bit got_done, fired;
    logic [7:0] stall_byte;
    s = sel ? 1 : 0; gap = sel ? 2 : 0;
    nw = 0; stalled = 0; got_done = 0; fired = 0; cfg_cyc = -10; done_cyc = -1;
    for (int i = 0; i < 64; i++) begin cap[i] = 8'hxx; wc[i] = -1; end
    @(negedge clk);
    start = 1'b1;
    if (sim_addr >= 0) begin
      cfg_valid = 1'b1; cfg_addr = 6'(sim_addr); cfg_data = sim_data;
      model_write(s, sim_addr, sim_data);
    end
    stall_byte = (stall_idx >= 0) ? exp_byte(s, stall_idx) : 8'h00;
    @(negedge clk);
    start = 1'b0; cfg_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      blk_ready = !(stall_idx >= 0 && nw == stall_idx && stalled < stall_len);
      cfg_valid = 1'b0;
      if (cfg_idx >= 0 && nw == cfg_idx && !fired) begin
        fired = 1; cfg_cyc = cyc;
        cfg_valid = 1'b1; cfg_addr = 6'd0; cfg_data = 8'hAA;
      end
      #1;
      if (cyc == 0) check("busy_streaming", bz, 1);
      if (cyc == cfg_cyc + 1) check("cfg_err_pulse", ce, 1);
      if (cyc == cfg_cyc + 2) check("cfg_err_clear", ce, 0);
      if (!blk_ready) begin
        stalled++;
        check("stall_no_write", ow, 0);
        check("stall_hold_data", od, stall_byte);
      end
      if (ow) begin
        if (nw < 64) begin cap[nw] = od; wc[nw] = cyc; end
        nw++;
      end
      if (dn) begin got_done = 1; done_cyc = cyc; end
    end
    check("done_seen", got_done, 1);
    // Start during DONE must be ignored.
    start = 1'b1; cfg_valid = 1'b0; blk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_in_done_ignored", bz, 0);
    check("done_one_cycle", dn, 0);
    check("write_count", nw, 64);
    check("done_after_last", done_cyc, wc[63] + 1);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      exp_wc = i * (gap + 1) + ((stall_idx >= 0 && i >= stall_idx) ? stall_len : 0);
      if (wc[i] != exp_wc) bad++;
    end
    check("write_spacing_errs", bad, 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (cap[i] !== exp_byte(s, i)) bad++;
    check("byte_errs", bad, 0);
    if (!sel) m_ctr[0] = m_ctr[0] + 32'd1;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start = 1'b0; cfg_valid = 1'b0; blk_ready = 1'b1;
    cfg_addr = 6'd0; cfg_data = 8'h00;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_out_write", out_write_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_cfg_err", cfg_err_a, 0);
    check("rst_ctr_wrap", ctr_wrap_a, 0);
    rst = 1'b0;

    // RFC 8439 2.3.2 vector.
    for (int i = 0; i < 32; i++) cfg_write(i, 8'(i));
    cfg_write(32, 8'h01); cfg_write(33, 8'h00); cfg_write(34, 8'h00); cfg_write(35, 8'h00);
    for (int i = 0; i < 12; i++) cfg_write(36 + i, 8'h00);
    cfg_write(39, 8'h09);
    cfg_write(43, 8'h4a);
    #1 check("cfg_err_idle", cfg_err_a, 0);
    run_stream(-1, 0, -1, -1, 8'h00);
    check("rfc_b0", cap[0], 8'h65);
    check("rfc_b1", cap[1], 8'h78);
    check("rfc_b2", cap[2], 8'h70);
    check("rfc_b3", cap[3], 8'h61);
    check("rfc_b16", cap[16], 8'h00);
    check("rfc_ctr", {cap[51], cap[50], cap[49], cap[48]}, 32'h0000_0001);
    check("rfc_nonce3", cap[55], 8'h09);
    check("rfc_nonce7", cap[59], 8'h4a);

    // Stall at byte 20 for 5 cycles, plus a dropped config write mid-stream.
    run_stream(20, 5, 40, -1, 8'h00);
    check("ctr_after_one", cap[48], 8'h02);
    check("stall_b20", cap[20], 8'h04);

    run_stream(-1, 0, -1, -1, 8'h00);
    check("busy_cfg_dropped_b16", cap[16], 8'h00);
    check("ctr_after_two", cap[48], 8'h03);
    check("no_wrap_yet", ctr_wrap_a, 0);

    // Counter wrap.
    for (int a = 32; a < 36; a++) cfg_write(a, 8'hFF);
    run_stream(-1, 0, -1, -1, 8'h00);
    check("wrap_ctr_bytes", {cap[51], cap[50], cap[49], cap[48]}, 32'hFFFF_FFFF);
    check("wrap_flag_set", ctr_wrap_a, 1);
    cfg_write(32, 8'h05);
    #1 check("wrap_flag_cleared", ctr_wrap_a, 0);

    // Config write in the same cycle as start lands in this stream.
    run_stream(-1, 0, -1, 16, 8'h5A);
    check("sim_cfg_b32", cap[32], 8'h5A);
    check("ctr_after_wrap_write", {cap[51], cap[50], cap[49], cap[48]}, 32'h0000_0005);

    // GAP_CYCLES=2, AUTO_INC=0 build.
    sel = 1'b1;
    cfg_write(32, 8'h07);
    run_stream(-1, 0, -1, -1, 8'h00);
    check("gap_first_write", wc[0], 0);
    check("gap_b1_cycle", wc[1], 3);
    check("gap_done_cycle", done_cyc, 190);
    run_stream(-1, 0, -1, -1, 8'h00);
    check("noinc_ctr", {cap[51], cap[50], cap[49], cap[48]}, 32'h0000_0007);
    check("noinc_b0", cap[0], 8'h65);
    sel = 1'b0;

    // Reset at byte 30.
    @(negedge clk);
    start = 1'b1; blk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nw = 0;
    for (int c = 0; c < 100 && nw < 30; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (out_write_a) nw++;
    end
    check("pre_rst_writes", nw, 30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_write", out_write_a, 0);
    check("midrst_busy", busy_a, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run_stream(-1, 0, -1, -1, 8'h00);
    check("post_rst_b0", cap[0], 8'h65);
    check("post_rst_b16", cap[16], 8'h00);
    check("post_rst_b47", cap[47], 8'h00);
    check("post_rst_ctr", cap[48], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
